// File: rtl/fetch_unit.sv
// fetch_unit: PC generation, in-order imem request tracking and decoupling fetch queue
// with redirect flush, stale-response dropping and misaligned-PC trap injection.
module fetch_unit #(
  parameter int PC_W = 48,
  parameter int FQ_DEPTH = 4,
  parameter int MAX_OUT = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [PC_W-1:0] imem_req_pc,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_instr,
  output logic [PC_W-1:0] bp_pc,
  input  logic            bp_taken,
  input  logic [PC_W-1:0] bp_target,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [PC_W-1:0] dec_pc,
  output logic [31:0]     dec_instr,
  output logic            dec_pred_taken,
  output logic [PC_W-1:0] dec_pred_pc,
  output logic            dec_trap
);
  localparam int AW = $clog2(FQ_DEPTH);
  localparam int MW = MAX_OUT > 1 ? $clog2(MAX_OUT) : 1;
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int UW = AW + 2;
  localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUT);
  localparam logic [UW-1:0] FQ_CAP = UW'(FQ_DEPTH);
  localparam logic [MW-1:0] M_LAST = MW'(MAX_OUT - 1);
  logic [PC_W-1:0] pc_q, pc_d, npc;
  logic [AW:0] cnt_q, cnt_d;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [MW-1:0] mw_q, mw_d, mr_q, mr_d;
  logic [OW-1:0] out_q, out_d, drop_q, drop_d;
  logic trap_q, trap_d;
  logic [UW-1:0] used;
  logic fire, resp, keep, trap_fire, fq_push, fq_pop;
  logic [PC_W-1:0] fq_pc [FQ_DEPTH];
  logic [PC_W-1:0] fq_ppc [FQ_DEPTH];
  logic [31:0] fq_instr [FQ_DEPTH];
  logic fq_pt [FQ_DEPTH];
  logic fq_trap [FQ_DEPTH];
  logic [PC_W-1:0] mq_pc [MAX_OUT];
  logic [PC_W-1:0] mq_npc [MAX_OUT];
  logic mq_pt [MAX_OUT];
  // Every in-flight request holds a queue slot, so a response can always be accepted.
  always_comb begin
    used = UW'(out_q) + UW'(cnt_q);
    imem_req_valid = !redirect_valid && !trap_q && pc_q[1:0] == 2'b00 && out_q < OUT_MAX && used < FQ_CAP;
    fire = imem_req_valid && imem_req_ready;
    npc = bp_taken ? bp_target : pc_q + PC_W'(4);
    resp = imem_resp_valid;
    keep = resp && drop_q == '0 && !redirect_valid;
    trap_fire = !redirect_valid && !trap_q && pc_q[1:0] != 2'b00 && out_q == '0 && UW'(cnt_q) < FQ_CAP;
    dec_valid = !redirect_valid && cnt_q != '0;
    fq_push = keep || trap_fire;
    fq_pop = dec_valid && dec_ready;
    pc_d = redirect_valid ? redirect_pc : fire ? npc : pc_q;
    out_d = out_q + OW'(fire) - OW'(resp);
    drop_d = redirect_valid ? out_q - OW'(resp) : (resp && drop_q != '0) ? drop_q - OW'(1) : drop_q;
    trap_d = !redirect_valid && (trap_q || trap_fire);
    cnt_d = redirect_valid ? '0 : cnt_q + (AW+1)'(fq_push) - (AW+1)'(fq_pop);
    wp_d = redirect_valid ? '0 : wp_q + AW'(fq_push);
    rp_d = redirect_valid ? '0 : rp_q + AW'(fq_pop);
    mw_d = fire ? (mw_q == M_LAST ? '0 : mw_q + MW'(1)) : mw_q;
    mr_d = resp ? (mr_q == M_LAST ? '0 : mr_q + MW'(1)) : mr_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
      cnt_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      mw_q <= '0;
      mr_q <= '0;
      out_q <= '0;
      drop_q <= '0;
      trap_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      cnt_q <= cnt_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      mw_q <= mw_d;
      mr_q <= mr_d;
      out_q <= out_d;
      drop_q <= drop_d;
      trap_q <= trap_d;
    end
  end
  // Metadata pops on every response, dropped or not, so it stays aligned with imem order.
  always_ff @(posedge clk) begin
    if (fq_push) begin
      fq_pc[wp_q] <= keep ? mq_pc[mr_q] : pc_q;
      fq_instr[wp_q] <= keep ? imem_resp_instr : 32'h0;
      fq_pt[wp_q] <= keep ? mq_pt[mr_q] : 1'b0;
      fq_ppc[wp_q] <= keep ? mq_npc[mr_q] : pc_q;
      fq_trap[wp_q] <= !keep;
    end
    if (fire) begin
      mq_pc[mw_q] <= pc_q;
      mq_pt[mw_q] <= bp_taken;
      mq_npc[mw_q] <= npc;
    end
  end
  assign imem_req_pc = pc_q;
  assign bp_pc = pc_q;
  assign dec_pc = fq_pc[rp_q];
  assign dec_instr = fq_instr[rp_q];
  assign dec_pred_taken = fq_pt[rp_q];
  assign dec_pred_pc = fq_ppc[rp_q];
  assign dec_trap = fq_trap[rp_q];
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table plus hand-written redirect, backpressure and trap sequences
// against a small in-order imem model (1-cycle latency, responses can be held).
module tb_fetch_unit;
  localparam int PW = 48;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic imem_req_valid, imem_req_ready = 1'b1;
  logic [PW-1:0] imem_req_pc;
  logic imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_instr = 32'h0;
  logic [PW-1:0] bp_pc, bp_target = '0;
  logic bp_taken = 1'b0;
  logic redirect_valid = 1'b0;
  logic [PW-1:0] redirect_pc = '0;
  logic dec_valid, dec_ready = 1'b1;
  logic [PW-1:0] dec_pc, dec_pred_pc;
  logic [31:0] dec_instr;
  logic dec_pred_taken, dec_trap;
  logic hold = 1'b0;
  int tests = 0;
  int fails = 0;

  fetch_unit #(.PC_W(PW), .FQ_DEPTH(4), .MAX_OUT(2), .RESET_PC(48'h1000)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_pc(imem_req_pc),
    .imem_resp_valid(imem_resp_valid), .imem_resp_instr(imem_resp_instr),
    .bp_pc(bp_pc), .bp_taken(bp_taken), .bp_target(bp_target),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc), .dec_instr(dec_instr),
    .dec_pred_taken(dec_pred_taken), .dec_pred_pc(dec_pred_pc), .dec_trap(dec_trap)
  );

  // imem model: in-order, answers one cycle after acceptance unless hold is set; instr = ~pc.
  logic [PW-1:0] mq[$];
  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      imem_resp_valid <= 1'b0;
    end else begin
      if (imem_req_valid && imem_req_ready) mq.push_back(imem_req_pc);
      if (!hold && mq.size() > 0) begin
        imem_resp_valid <= 1'b1;
        imem_resp_instr <= ~mq[0][31:0];
        void'(mq.pop_front());
      end else imem_resp_valid <= 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    bp_taken = 1'b0;
    hold = 1'b0;
    dec_ready = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic wait_dec(input string name);
    int n = 0;
    #1;
    while (!dec_valid && n < 20) begin
      cyc();
      #1;
      n++;
    end
    if (!dec_valid) begin
      tests++;
      fails++;
      $display("FAIL %s: timeout, dec_valid 0 expected 1", name);
    end
  endtask

  typedef struct {
    bit rst;
    bit bpt;
    logic [PW-1:0] tgt;
    bit ev;
    logic [PW-1:0] epc;
    bit edv;
    logic [PW-1:0] edpc;
    bit ept;
    logic [PW-1:0] eppc;
  } vec_t;
  vec_t tbl[11];

  initial begin
    logic [31:0] ei;
    int fires, pops, bad;
    logic [PW-1:0] nx;
    tbl[0]  = '{0, 0, 48'h0,    1, 48'h1000, 0, 48'h0,    0, 48'h0};
    tbl[1]  = '{0, 0, 48'h0,    1, 48'h1004, 0, 48'h0,    0, 48'h0};
    tbl[2]  = '{0, 0, 48'h0,    1, 48'h1008, 1, 48'h1000, 0, 48'h1004};
    tbl[3]  = '{0, 0, 48'h0,    1, 48'h100C, 1, 48'h1004, 0, 48'h1008};
    tbl[4]  = '{0, 0, 48'h0,    1, 48'h1010, 1, 48'h1008, 0, 48'h100C};
    tbl[5]  = '{1, 0, 48'h0,    0, 48'h0,    0, 48'h0,    0, 48'h0};
    tbl[6]  = '{0, 0, 48'h0,    1, 48'h1000, 0, 48'h0,    0, 48'h0};
    tbl[7]  = '{0, 1, 48'h2000, 1, 48'h1004, 0, 48'h0,    0, 48'h0};
    tbl[8]  = '{0, 0, 48'h0,    1, 48'h2000, 1, 48'h1000, 0, 48'h1004};
    tbl[9]  = '{0, 0, 48'h0,    1, 48'h2004, 1, 48'h1004, 1, 48'h2000};
    tbl[10] = '{0, 0, 48'h0,    1, 48'h2008, 1, 48'h2000, 0, 48'h2004};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      reset = tbl[i].rst;
      bp_taken = tbl[i].bpt;
      bp_target = tbl[i].tgt;
      #1;
      if (!tbl[i].rst) begin
        chk($sformatf("v%0d req_valid", i), imem_req_valid, tbl[i].ev);
        chk($sformatf("v%0d req_pc", i), imem_req_pc, tbl[i].epc);
        chk($sformatf("v%0d bp_pc", i), bp_pc, tbl[i].epc);
        chk($sformatf("v%0d dec_valid", i), dec_valid, tbl[i].edv);
        if (tbl[i].edv) begin
          ei = ~tbl[i].edpc[31:0];
          chk($sformatf("v%0d dec_pc", i), dec_pc, tbl[i].edpc);
          chk($sformatf("v%0d dec_instr", i), dec_instr, ei);
          chk($sformatf("v%0d pred_taken", i), dec_pred_taken, tbl[i].ept);
          chk($sformatf("v%0d pred_pc", i), dec_pred_pc, tbl[i].eppc);
          chk($sformatf("v%0d dec_trap", i), dec_trap, 1'b0);
        end
      end
      cyc();
    end
    reset = 1'b0;
    bp_taken = 1'b0;

    // backpressure: queue of 4 fills, then requests stop; release drains in order
    do_reset();
    dec_ready = 1'b0;
    fires = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (imem_req_valid && imem_req_ready) fires++;
      cyc();
    end
    #1;
    chk("bp_fires", fires, 4);
    chk("bp_stall_req", imem_req_valid, 1'b0);
    chk("bp_head_valid", dec_valid, 1'b1);
    chk("bp_head_pc", dec_pc, 48'h1000);
    cyc();
    dec_ready = 1'b1;
    nx = 48'h1000;
    pops = 0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (dec_valid) begin
        chk("bp_order", dec_pc, nx);
        nx = nx + 48'd4;
        pops++;
      end
      cyc();
    end
    chk("bp_throughput", pops >= 25, 1'b1);

    // redirect with two requests in flight and one entry queued
    do_reset();
    dec_ready = 1'b0;
    #1;
    cyc();
    hold = 1'b1;
    #1;
    cyc();
    #1;
    chk("rd_second_fire", imem_req_valid, 1'b1);
    cyc();
    #1;
    chk("rd_max_out", imem_req_valid, 1'b0);
    chk("rd_pre_dec_valid", dec_valid, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc = 48'h3000;
    #1;
    chk("rd_req_suppressed", imem_req_valid, 1'b0);
    chk("rd_dec_suppressed", dec_valid, 1'b0);
    cyc();
    redirect_valid = 1'b0;
    hold = 1'b0;
    dec_ready = 1'b1;
    wait_dec("rd_wait");
    ei = ~32'h3000;
    chk("rd_first_pc", dec_pc, 48'h3000);
    chk("rd_first_instr", dec_instr, ei);
    chk("rd_first_trap", dec_trap, 1'b0);
    cyc();
    #1;
    chk("rd_next_valid", dec_valid, 1'b1);
    chk("rd_next_pc", dec_pc, 48'h3004);
    cyc();

    // misaligned redirect: one trap entry, stall until a new redirect
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 48'h3002;
    #1;
    cyc();
    redirect_valid = 1'b0;
    #1;
    chk("mis_no_req", imem_req_valid, 1'b0);
    cyc();
    #1;
    chk("mis_dec_valid", dec_valid, 1'b1);
    chk("mis_dec_trap", dec_trap, 1'b1);
    chk("mis_dec_pc", dec_pc, 48'h3002);
    chk("mis_pred_pc", dec_pred_pc, 48'h3002);
    chk("mis_pred_taken", dec_pred_taken, 1'b0);
    chk("mis_instr", dec_instr, 32'h0);
    cyc();
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (imem_req_valid || dec_valid) bad++;
      cyc();
    end
    chk("mis_stalled", bad, 0);
    redirect_valid = 1'b1;
    redirect_pc = 48'h4000;
    #1;
    cyc();
    redirect_valid = 1'b0;
    #1;
    chk("mis_resume_req", imem_req_valid, 1'b1);
    chk("mis_resume_pc", imem_req_pc, 48'h4000);
    cyc();
    wait_dec("mis_wait");
    chk("mis_resume_dec_pc", dec_pc, 48'h4000);
    chk("mis_resume_trap", dec_trap, 1'b0);
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 48: PC and target width.
REQ-002 SHALL have parameter FQ_DEPTH, default 4: fetch-queue entries (power of 2, >=2).
REQ-003 SHALL have parameter MAX_OUT, default 2: maximum outstanding imem requests (1..FQ_DEPTH).
REQ-004 SHALL have parameter RESET_PC, default 0: PC loaded on reset.
REQ-005 SHALL use one clock; reset is synchronous and active-high. Ports: clk in 1, clock; reset in 1, sync active-high reset.
REQ-006 imem_req_valid out 1: fetch request valid. imem_req_ready in 1: imem accepts request. imem_req_pc out PC_W: request address.
REQ-007 imem_resp_valid in 1: response valid, in order, one per accepted request, >=1 cycle after acceptance. imem_resp_instr in 32: instruction word.
REQ-008 bp_pc out PC_W: current PC to predictor. bp_taken in 1 and bp_target in PC_W: combinational prediction for bp_pc.
REQ-009 redirect_valid in 1 and redirect_pc in PC_W: mispredict/trap redirect from EX.
REQ-010 dec_valid out 1, dec_ready in 1: decode handshake. dec_pc out PC_W, dec_instr out 32, dec_pred_taken out 1, dec_pred_pc out PC_W, dec_trap out 1: queue head payload.

Function
REQ-011 The PC register SHALL drive imem_req_pc and bp_pc; a fire is imem_req_valid && imem_req_ready.
REQ-012 imem_req_valid SHALL be 1 only when: no redirect_valid, no trap_pending, pc[1:0]==0, outstanding < MAX_OUT, and outstanding + fq_count < FQ_DEPTH (a slot is reserved per in-flight request).
REQ-013 On fire, PC SHALL become bp_target if bp_taken, else PC+4 modulo 2^PC_W; {PC, bp_taken, next PC} SHALL be pushed into an in-flight metadata FIFO of depth MAX_OUT.
REQ-014 outstanding SHALL increment on fire, decrement on imem_resp_valid, and be unchanged when both occur in one cycle.
REQ-015 On imem_resp_valid with drop_cnt==0, the metadata head SHALL pop and {pc, instr, pred_taken, pred_pc, trap=0} SHALL be pushed into the fetch queue in the same cycle.
REQ-016 On imem_resp_valid with drop_cnt>0, the response and metadata head SHALL be discarded and drop_cnt SHALL decrement.
REQ-017 redirect_valid SHALL have priority over every other event. It SHALL: load PC with redirect_pc, empty the fetch queue, clear trap_pending, and suppress imem_req_valid and dec_valid that cycle. It SHALL also set drop_cnt to the outstanding count after that cycle's response, so every pre-redirect response is dropped.
REQ-018 A redirect while drop_cnt>0 SHALL recompute drop_cnt per REQ-017 (no epoch aliasing).
REQ-019 If pc[1:0]!=0 and trap_pending==0 and outstanding==0 and the fetch queue is not full, the block SHALL push {pc, instr=0, pred_taken=0, pred_pc=pc, trap=1}, set trap_pending, and issue no request until redirect.
REQ-020 dec_valid SHALL equal fetch queue non-empty (except per REQ-017); head pops on dec_valid && dec_ready; push and pop in the same cycle SHALL be allowed, with the count unchanged.
REQ-021 The fetch queue SHALL never overflow by construction (REQ-012); read/write pointers wrap modulo FQ_DEPTH.
REQ-022 Latency: an accepted request SHALL appear on dec_* in the cycle after its response at the earliest; back-to-back fires every cycle SHALL be sustained while credits allow.

Reset
REQ-023 While reset is high at a clk edge: PC=RESET_PC; fetch queue, metadata FIFO, outstanding, drop_cnt and trap_pending SHALL be cleared.
REQ-024 In the cycle after reset: imem_req_valid=1 if RESET_PC is aligned, and dec_valid=0.
REQ-025 Reset asserted mid-operation SHALL discard all state. Responses to pre-reset requests SHALL NOT be issued by imem after reset (imem shares the reset).

Verification
REQ-026 Sequential stream: RESET_PC=0x1000, ready=1, bp_taken=0, 1-cycle imem -> requests 0x1000, 0x1004, 0x1008; dec_pc in the same order with dec_trap=0.
REQ-027 Prediction: bp_taken=1, bp_target=0x2000 at pc 0x1004 -> next request 0x2000; dec_pred_taken=1 and dec_pred_pc=0x2000 on the 0x1004 entry.
REQ-028 Backpressure: dec_ready=0 with FQ_DEPTH=4 -> exactly 4 requests accepted, then imem_req_valid=0; dec_ready=1 resumes with no loss or duplication.
REQ-029 Redirect with 2 outstanding: redirect_pc=0x3000 -> queue flushed, 2 responses dropped, first dec_pc=0x3000.
REQ-030 Misaligned: redirect_pc=0x3002 -> no imem request; one entry with dec_trap=1 and dec_pc=0x3002; fetch stalls until redirect_pc=0x4000, then resumes at 0x4000.
